// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for the seven-segment scan controller.
// The host drives the value/load side; the controller drives the scan side.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp;
    logic              load;
    logic              lzb;
    logic [3:0]        nibble;
    logic              dp_out;
    logic [NDIG-1:0]   dig_n;
    logic              busy;
    logic              frame;

    modport master (
        output value,
        output dp,
        output load,
        output lzb,
        input  nibble,
        input  dp_out,
        input  dig_n,
        input  busy,
        input  frame
    );

    modport slave (
        input  value,
        input  dp,
        input  load,
        input  lzb,
        output nibble,
        output dp_out,
        output dig_n,
        output busy,
        output frame
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, double-buffered
// display value, per-slot blanking guard and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 500
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] disp;
    logic [NDIG-1:0]   ddp;
    logic [4*NDIG-1:0] pv;
    logic [NDIG-1:0]   pdp;
    logic              pend;

    logic              slot_end;
    logic              last_dig;
    logic              frame_end;
    logic              guard_blank;
    logic              lz_blank;
    logic              blank;
    logic [NDIG-1:0]   zhi;
    logic [NDIG-1:0]   sel_n;

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign last_dig  = (idx == IW'(NDIG - 1));
    assign frame_end = slot_end && last_dig;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= '0;
            disp <= '0;
            ddp  <= '0;
            pv   <= '0;
            pdp  <= '0;
            pend <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= last_dig ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_end && pend) begin
                disp <= pv;
                ddp  <= pdp;
            end

            // a load on the boundary commits the old value and stays pending
            if (bus.load) begin
                pv   <= bus.value;
                pdp  <= bus.dp;
                pend <= 1'b1;
            end else if (frame_end) begin
                pend <= 1'b0;
            end
        end
    end

    // zhi[k]: digits k..NDIG-1 of the displayed value are all zero
    always_comb begin
        logic run;
        run = 1'b1;
        zhi = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            run    = run && (disp[4*k +: 4] == 4'h0);
            zhi[k] = run;
        end
    end

    assign guard_blank = (GUARD > 0) && (int'(cnt) < GUARD);
    assign lz_blank    = bus.lzb && (idx != '0) && zhi[idx];
    assign blank       = guard_blank || lz_blank;

    always_comb begin
        sel_n = '1;
        if (!blank) begin
            sel_n[idx] = 1'b0;
        end
    end

    assign bus.nibble = disp[4*idx +: 4];
    assign bus.dp_out = ddp[idx];
    assign bus.dig_n  = sel_n;
    assign bus.busy   = pend;
    assign bus.frame  = frame_end;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with NDIG=4, DIV=8, GUARD=2.
// Stimulus queues hand-derived per-cycle outputs; a negedge monitor checks them.
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NDIG(4)) bus ();

    seg7_scan_ctrl #(
        .NDIG  (4),
        .DIV   (8),
        .GUARD (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] nib;
        logic [3:0] dign;
        logic       dpo;
        logic       frm;
        logic       bsy;
    } exp_t;

    exp_t sbq[$];
    int   acyc = 0;
    int   base = 0;
    int   tests = 0;
    int   fails = 0;
    bit   fin = 1'b0;
    bit   fin_seen = 1'b0;

    always @(posedge clk) acyc <= acyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= acyc) begin
            e = sbq.pop_front();
            tests++;
            if (e.cyc < acyc) begin
                fails++;
                $display("FAIL %s: never sampled (cycle %0d, now %0d)",
                         e.name, e.cyc, acyc);
            end else if ({bus.nibble, bus.dig_n, bus.dp_out, bus.frame,
                          bus.busy} !==
                         {e.nib, e.dign, e.dpo, e.frm, e.bsy}) begin
                fails++;
                $display({"FAIL %s: got nib=%h dig_n=%b dp=%b frame=%b ",
                          "busy=%b, want nib=%h dig_n=%b dp=%b frame=%b busy=%b"},
                         e.name, bus.nibble, bus.dig_n, bus.dp_out,
                         bus.frame, bus.busy, e.nib, e.dign, e.dpo,
                         e.frm, e.bsy);
            end
        end
        if (fin && !fin_seen) begin
            fin_seen = 1'b1;
            tests++;
            if (sbq.size() != 0) begin
                fails++;
                $display("FAIL drain: got %0d unchecked entries, want 0",
                         sbq.size());
            end
        end
    end

    // Queue one frame (or its first n cycles) starting at scan time fs.
    // busy is expected high for scan times in [blo, bhi).
    task automatic expect_frame(input int fs, input int n,
                                input logic [15:0] v, input logic [3:0] d,
                                input logic [3:0] lit,
                                input int blo, input int bhi);
        exp_t       e;
        logic [3:0] oh;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                int t;
                t = fs + 8 * s + c;
                if (t - fs < n) begin
                    oh     = 4'b0001 << s;
                    e.cyc  = base + t;
                    e.name = $sformatf("scan_t%0d", t);
                    e.nib  = v[4*s +: 4];
                    e.dign = (c < 2 || !lit[s]) ? 4'hF : ~oh;
                    e.dpo  = d[s];
                    e.frm  = (s == 3) && (c == 7);
                    e.bsy  = (t >= blo) && (t < bhi);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic to_t(input int t);
        while (acyc < base + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp    = d;
        bus.load  = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.value = '0;
        bus.dp    = '0;
        bus.load  = 1'b0;
        bus.lzb   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        base = acyc;
        rst  = 1'b0;

        expect_frame(0,   32, 16'h0000, 4'b0000, 4'b1111, 1,   32);
        expect_frame(32,  32, 16'h1234, 4'b0000, 4'b1111, 44,  64);
        expect_frame(64,  32, 16'hABCD, 4'b0000, 4'b1111, 0,   0);
        expect_frame(96,  32, 16'hABCD, 4'b0000, 4'b1111, 99,  128);
        expect_frame(128, 32, 16'h2222, 4'b0000, 4'b1111, 128, 160);
        expect_frame(160, 32, 16'h3333, 4'b0000, 4'b1111, 161, 192);
        expect_frame(192, 32, 16'h0050, 4'b0000, 4'b0011, 193, 224);
        expect_frame(224, 32, 16'h0000, 4'b0000, 4'b0001, 0,   0);
        expect_frame(256, 32, 16'h0000, 4'b0000, 4'b1111, 257, 288);
        expect_frame(288, 32, 16'h1234, 4'b0100, 4'b1111, 0,   0);
        expect_frame(320, 22, 16'h1234, 4'b0100, 4'b1111, 322, 342);

        do_load(16'h1234, 4'b0000);
        to_t(43);
        do_load(16'hABCD, 4'b0000);
        to_t(98);
        do_load(16'h1111, 4'b0000);
        to_t(100);
        do_load(16'h2222, 4'b0000);
        to_t(127);
        do_load(16'h3333, 4'b0000);
        to_t(160);
        do_load(16'h0050, 4'b0000);
        to_t(192);
        bus.lzb = 1'b1;
        do_load(16'h0000, 4'b0000);
        to_t(256);
        bus.lzb = 1'b0;
        do_load(16'h1234, 4'b0100);
        to_t(321);
        do_load(16'hFFFF, 4'b0000);
        to_t(341);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = acyc;
        expect_frame(0,  32, 16'h0000, 4'b0000, 4'b1111, 0, 0);
        expect_frame(32, 32, 16'h0000, 4'b0000, 4'b1111, 0, 0);
        to_t(64);

        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            @(posedge clk);
        end
        fin = 1'b1;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
